// File: rtl/enc_2.sv
// 4-to-2 priority encoder (D3 highest) with valid and multi-request flags.
// x/y/V are registered or combinational by REG_OUT; multi is always registered.
module enc_2 #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  output logic x,
  output logic y,
  output logic V,
  output logic multi
);

  logic x_c;
  logic y_c;
  logic v_c;
  logic multi_c;
  logic multi_q;

  // Index bits are zero when nothing is requested, never don't-care.
  assign x_c = D3 | D2;
  assign y_c = D3 | (D1 & ~D2);
  assign v_c = D0 | D1 | D2 | D3;
  assign multi_c = (D3 & D2) | (D3 & D1) | (D3 & D0) |
                   (D2 & D1) | (D2 & D0) | (D1 & D0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_q <= 1'b0;
    end else begin
      multi_q <= multi_c;
    end
  end

  assign multi = multi_q;

  generate
    if (REG_OUT) begin : g_reg
      logic x_q;
      logic y_q;
      logic v_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q <= 1'b0;
          y_q <= 1'b0;
          v_q <= 1'b0;
        end else begin
          x_q <= x_c;
          y_q <= y_c;
          v_q <= v_c;
        end
      end

      assign x = x_q;
      assign y = y_q;
      assign V = v_q;
    end else begin : g_comb
      assign x = x_c;
      assign y = y_c;
      assign V = v_c;
    end
  endgenerate

endmodule

// File: tb/tb_enc_2.sv
// Scoreboard bench for enc_2: registered instance checked by a queue-driven
// monitor, combinational instance checked in zero-clock sweeps.
module tb_enc_2;

  logic clk;
  logic rst_n;
  logic [3:0] d_r;
  logic [3:0] d_c;
  logic x_r, y_r, v_r, multi_r;
  logic x_c, y_c, v_c, multi_c;

  int checks;
  int failures;
  logic [3:0] exp_q[$];

  enc_2 #(.REG_OUT(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n),
    .D0(d_r[0]), .D1(d_r[1]), .D2(d_r[2]), .D3(d_r[3]),
    .x(x_r), .y(y_r), .V(v_r), .multi(multi_r)
  );

  enc_2 #(.REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .D0(d_c[0]), .D1(d_c[1]), .D2(d_c[2]), .D3(d_c[3]),
    .x(x_c), .y(y_c), .V(v_c), .multi(multi_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: index of highest set line, valid if any, multi if two or more.
  function automatic logic [3:0] model(input logic [3:0] d);
    int idx;
    logic [1:0] xy;
    logic v;
    logic m;
    idx = -1;
    for (int i = 0; i < 4; i++) if (d[i]) idx = i;
    v = (idx >= 0);
    xy = v ? 2'(idx) : 2'b00;
    m = ($countones(d) >= 2);
    return {xy, v, m};
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got xyVm=%b expected %b", name, got, want);
    end
  endtask

  task automatic check3(input string name, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got xyV=%b expected %b", name, got, want);
    end
  endtask

  task automatic apply(input logic [3:0] d);
    @(negedge clk);
    d_r = d;
    exp_q.push_back(model(d));
  endtask

  // Monitor: registered outputs present a new result after every edge.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {x_r, y_r, v_r, multi_r}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    checks = 0;
    failures = 0;
    rst_n = 1'b1;
    d_r = 4'b0000;
    d_c = 4'b0000;
    #1;
    rst_n = 1'b0;
    d_r = 4'b1111;
    #2;
    check("reset_no_clk", {x_r, y_r, v_r, multi_r}, 4'b0000);

    @(negedge clk);
    check("reset_held", {x_r, y_r, v_r, multi_r}, 4'b0000);
    rst_n = 1'b1;
    exp_q.push_back(model(d_r));

    for (int v = 0; v < 16; v++) apply(4'(v));

    apply(4'b1111);
    apply(4'b0110);
    apply(4'b0100);

    apply(4'b0000);
    @(negedge clk);
    d_r = 4'b0010;
    #1;
    check("latency_not_before", {x_r, y_r, v_r, multi_r}, model(4'b0000));
    exp_q.push_back(model(4'b0010));

    for (int i = 0; i < 150; i++) apply(4'($urandom_range(0, 15)));

    apply(4'b1000);
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      #2;
      budget++;
    end
    if (exp_q.size() > 0) check("drain_before_reset", 4'(exp_q.size()), 4'd0);
    exp_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_reset", {x_r, y_r, v_r, multi_r}, 4'b0000);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_release_hold", {x_r, y_r, v_r, multi_r}, 4'b0000);
    exp_q.push_back(model(4'b1000));

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      #2;
      budget++;
    end
    if (exp_q.size() > 0) check("drain_final", 4'(exp_q.size()), 4'd0);

    for (int v = 0; v < 16; v++) begin
      logic [3:0] m;
      d_c = 4'(v);
      #1;
      m = model(4'(v));
      check3("comb_sweep", {x_c, y_c, v_c}, m[3:1]);
    end
    for (int i = 0; i < 20; i++) begin
      logic [3:0] m;
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      d_c = r;
      #1;
      m = model(r);
      check3("comb_random", {x_c, y_c, v_c}, m[3:1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
